// File: rtl/axi4lite_csr_mst_pkg.sv
// Shared types and constants for the CSR-to-AXI4-lite master.
package axi4lite_csr_mst_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RSP,
    RD_REQ,
    RD_RSP,
    RSP
  } t_csr_mst_state;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic bit data_w_ok(input int w);
    return (w == 32) || (w == 64);
  endfunction

endpackage

// File: rtl/ofs_fim_axi_lite_if.sv
// AXI4-lite signal bundle with master/slave views.
interface ofs_fim_axi_lite_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 64
);
  logic                awvalid, awready;
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                wvalid, wready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                bvalid, bready;
  logic [1:0]          bresp;
  logic                arvalid, arready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                rvalid, rready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi4lite_csr_mst_tmo.sv
// Outstanding-transaction watchdog; used only when AXI4LITE_CSR_MST_TIMEOUT_EN is defined.
module axi4lite_csr_mst_tmo #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                     cnt_d = '0;
    else if (en_i && cnt_q != LAST) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/axi4lite_csr_mst.sv
// Single-outstanding CSR request/response to AXI4-lite master bridge.
// Optional watchdog and idle B/R sinking under AXI4LITE_CSR_MST_TIMEOUT_EN.
module axi4lite_csr_mst
  import axi4lite_csr_mst_pkg::*;
#(
  parameter int ADDR_W         = 20,
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                csr_req_valid,
  output logic                csr_req_ready,
  input  logic                csr_req_write,
  input  logic [ADDR_W-1:0]   csr_req_addr,
  input  logic [DATA_W-1:0]   csr_req_wdata,
  input  logic [DATA_W/8-1:0] csr_req_wstrb,
  output logic                csr_rsp_valid,
  output logic [DATA_W-1:0]   csr_rsp_rdata,
  output logic                csr_rsp_err,
  output logic                csr_rsp_timeout,
  ofs_fim_axi_lite_if.master  m_axil
);

  if (!data_w_ok(DATA_W) || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("axi4lite_csr_mst: DATA_W must be 32 or 64 and TIMEOUT_CYCLES >= 2");
  end

  t_csr_mst_state      state_q, state_d;
  logic                req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d, wdata_q, wdata_d;
  logic                err_q, err_d, tmo_q, tmo_d;
  logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic                bready_q, bready_d, rready_q, rready_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic                tmo_expire;

`ifdef AXI4LITE_CSR_MST_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
  axi4lite_csr_mst_tmo #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (state_q == IDLE),
    .en_i     (state_q != IDLE && state_q != RSP),
    .expire_o (tmo_expire)
  );
`else
  localparam bit TMO_EN = 1'b0;
  assign tmo_expire = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    err_d       = err_q;
    tmo_d       = tmo_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    bready_d    = bready_q;
    rready_d    = rready_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    unique case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        bready_d    = TMO_EN;
        rready_d    = TMO_EN;
        if (csr_req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          addr_d      = csr_req_addr;
          wdata_d     = csr_req_wdata;
          wstrb_d     = csr_req_wstrb;
          rready_d    = 1'b0;
          bready_d    = csr_req_write;
          if (csr_req_write) begin
            state_d   = WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_REQ;
            arvalid_d = 1'b1;
          end
        end
      end
      WR_REQ: begin
        // A dropped valid doubles as that channel's done flag.
        if (m_axil.awready) awvalid_d = 1'b0;
        if (m_axil.wready)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          if (m_axil.bvalid && bready_q) begin
            state_d     = RSP;
            bready_d    = 1'b0;
            rsp_valid_d = 1'b1;
            err_d       = (m_axil.bresp != RESP_OKAY);
            tmo_d       = 1'b0;
            rdata_d     = '0;
          end else begin
            state_d = WR_RSP;
          end
        end
      end
      WR_RSP: begin
        if (m_axil.bvalid && bready_q) begin
          state_d     = RSP;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          err_d       = (m_axil.bresp != RESP_OKAY);
          tmo_d       = 1'b0;
          rdata_d     = '0;
        end
      end
      RD_REQ: begin
        if (m_axil.arready) begin
          state_d   = RD_RSP;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      RD_RSP: begin
        if (m_axil.rvalid && rready_q) begin
          state_d     = RSP;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          err_d       = (m_axil.rresp != RESP_OKAY);
          tmo_d       = 1'b0;
          rdata_d     = m_axil.rdata;
        end
      end
      RSP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        bready_d    = TMO_EN;
        rready_d    = TMO_EN;
      end
      default: state_d = IDLE;
    endcase
    // A real completion in the expiry cycle takes precedence over the forced one.
    if (tmo_expire && state_d != RSP) begin
      state_d     = RSP;
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      arvalid_d   = 1'b0;
      bready_d    = 1'b0;
      rready_d    = 1'b0;
      rsp_valid_d = 1'b1;
      err_d       = 1'b1;
      tmo_d       = 1'b1;
      rdata_d     = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      tmo_q       <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
    end
  end

  assign csr_req_ready   = req_ready_q;
  assign csr_rsp_valid   = rsp_valid_q;
  assign csr_rsp_rdata   = rdata_q;
  assign csr_rsp_err     = err_q;
  assign csr_rsp_timeout = tmo_q;

  assign m_axil.awvalid = awvalid_q;
  assign m_axil.awaddr  = addr_q;
  assign m_axil.awprot  = 3'b000;
  assign m_axil.wvalid  = wvalid_q;
  assign m_axil.wdata   = wdata_q;
  assign m_axil.wstrb   = wstrb_q;
  assign m_axil.bready  = bready_q;
  assign m_axil.arvalid = arvalid_q;
  assign m_axil.araddr  = addr_q;
  assign m_axil.arprot  = 3'b000;
  assign m_axil.rready  = rready_q;

endmodule

// File: tb/tb_axi4lite_csr_mst.sv
// Scoreboard bench for axi4lite_csr_mst with a configurable AXI4-lite slave model.
module tb_axi4lite_csr_mst;
  import axi4lite_csr_mst_pkg::*;

  localparam int AW = 20;
  localparam int DW = 64;
`ifdef AXI4LITE_CSR_MST_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
    logic          tmo;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0, req_write = 1'b0;
  logic [AW-1:0]   req_addr  = '0;
  logic [DW-1:0]   req_wdata = '0;
  logic [DW/8-1:0] req_wstrb = '0;
  logic req_ready, rsp_valid, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;

  ofs_fim_axi_lite_if #(.ADDR_W(AW), .DATA_W(DW)) axil ();

  axi4lite_csr_mst #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk            (clk),
    .rst            (rst),
    .csr_req_valid  (req_valid),
    .csr_req_ready  (req_ready),
    .csr_req_write  (req_write),
    .csr_req_addr   (req_addr),
    .csr_req_wdata  (req_wdata),
    .csr_req_wstrb  (req_wstrb),
    .csr_rsp_valid  (rsp_valid),
    .csr_rsp_rdata  (rsp_rdata),
    .csr_rsp_err    (rsp_err),
    .csr_rsp_timeout(rsp_timeout),
    .m_axil         (axil)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // slave model
  int            aw_delay = 0;
  bit            b_hold = 1'b0, ar_block = 1'b0;
  logic [DW-1:0] rd_val  = '0;
  logic [1:0]    rd_resp = RESP_OKAY;
  logic [1:0]    wr_resp = RESP_OKAY;
  int            aw_cnt;
  logic          got_aw, got_w, s_bvalid, s_rvalid;
  logic [DW-1:0] s_rdata;
  logic [1:0]    s_rresp;
  logic          aw_hs, w_hs, ar_hs;

  assign axil.awready = axil.awvalid && (aw_cnt >= aw_delay);
  assign axil.wready  = axil.wvalid;
  assign axil.arready = axil.arvalid && !ar_block;
  assign axil.bvalid  = s_bvalid;
  assign axil.bresp   = wr_resp;
  assign axil.rvalid  = s_rvalid;
  assign axil.rdata   = s_rdata;
  assign axil.rresp   = s_rresp;
  assign aw_hs = axil.awvalid && axil.awready;
  assign w_hs  = axil.wvalid && axil.wready;
  assign ar_hs = axil.arvalid && axil.arready;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_cnt <= 0; got_aw <= 1'b0; got_w <= 1'b0;
      s_bvalid <= 1'b0; s_rvalid <= 1'b0; s_rdata <= '0; s_rresp <= RESP_OKAY;
    end else begin
      if (aw_hs) aw_cnt <= 0;
      else if (axil.awvalid) aw_cnt <= aw_cnt + 1;
      if (aw_hs) got_aw <= 1'b1;
      if (w_hs)  got_w  <= 1'b1;
      if (s_bvalid && axil.bready) s_bvalid <= 1'b0;
      if ((got_aw || aw_hs) && (got_w || w_hs) && !b_hold) begin
        s_bvalid <= 1'b1; got_aw <= 1'b0; got_w <= 1'b0;
      end
      if (ar_hs) begin
        s_rvalid <= 1'b1; s_rdata <= rd_val; s_rresp <= rd_resp;
      end else if (s_rvalid && axil.rready) s_rvalid <= 1'b0;
    end
  end

  // scoreboard
  rsp_t sb[$];
  int total = 0, bad = 0, rsp_cnt = 0, rsp_cyc = 0;

  initial begin : monitor
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        rsp_cnt++;
        rsp_cyc = cyc;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: response with nothing pending, rdata=%h", rsp_rdata);
        end else begin
          e = sb.pop_front();
          total += 2;
          if (rsp_rdata !== e.rdata) begin
            bad++; $display("FAIL sb_rdata: got %h expected %h", rsp_rdata, e.rdata);
          end
          if ({rsp_err, rsp_timeout} !== {e.err, e.tmo}) begin
            bad++; $display("FAIL sb_err_tmo: got %b%b expected %b%b", rsp_err, rsp_timeout, e.err, e.tmo);
          end
        end
      end
    end
  end

  function automatic rsp_t mk(input logic [DW-1:0] d, input logic err, input logic tmo);
    rsp_t r;
    r.rdata = d; r.err = err; r.tmo = tmo;
    return r;
  endfunction

  // Called at a negedge; returns at the negedge of the cycle after acceptance.
  task automatic send(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [DW/8-1:0] s, input rsp_t exp, output int acc);
    int n = 0;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s;
    while (req_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    acc = cyc;
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL accept_wait: ready=%b required 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    sb.push_back(exp);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target, input int limit);
    int n = 0;
    while (rsp_cnt < target && n < limit) begin @(negedge clk); n++; end
    total++;
    if (rsp_cnt < target) begin
      bad++; $display("FAIL rsp_wait: got %0d responses required %0d", rsp_cnt, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total += 2;
    if ({req_ready, rsp_valid, rsp_err, rsp_timeout, axil.awvalid, axil.wvalid,
         axil.arvalid, axil.bready, axil.rready} !== 9'b1_0000_0000) begin
      bad++; $display("FAIL reset_ctrl: got %b required 100000000", {req_ready, rsp_valid, rsp_err,
        rsp_timeout, axil.awvalid, axil.wvalid, axil.arvalid, axil.bready, axil.rready});
    end
    if (rsp_rdata !== '0) begin
      bad++; $display("FAIL reset_rdata: got %h required 0", rsp_rdata);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read();
    int acc, base = rsp_cnt;
    rd_val = 64'h1234_5678_9ABC_DEF0; rd_resp = RESP_OKAY;
    send(1'b0, 20'h00200, '0, '0, mk(64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0), acc);
    total++;
    if ({axil.arvalid, axil.araddr} !== {1'b1, 20'h00200}) begin
      bad++; $display("FAIL read_ar: arvalid=%b araddr=%h required 1/00200", axil.arvalid, axil.araddr);
    end
    wait_rsp(base + 1, 20);
    total++;
    if (rsp_cyc - acc !== 3) begin
      bad++; $display("FAIL read_latency: got %0d required 3", rsp_cyc - acc);
    end
  endtask

  task automatic test_rdata_hold();
    repeat (2) @(negedge clk);
    total++;
    if ({rsp_valid, rsp_rdata} !== {1'b0, 64'h1234_5678_9ABC_DEF0}) begin
      bad++; $display("FAIL rdata_hold: valid=%b rdata=%h required 0/123456789abcdef0", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_write();
    int acc, base = rsp_cnt;
    send(1'b1, 20'h00100, 64'hDEAD_BEEF, 8'hFF, mk('0, 1'b0, 1'b0), acc);
    total += 2;
    if ({axil.awvalid, axil.wvalid, req_ready} !== 3'b110) begin
      bad++; $display("FAIL write_valids: aw/w/ready=%b required 110", {axil.awvalid, axil.wvalid, req_ready});
    end
    if ({axil.awaddr, axil.wdata, axil.wstrb, axil.awprot, axil.arprot} !==
        {20'h00100, 64'hDEAD_BEEF, 8'hFF, 6'b0}) begin
      bad++; $display("FAIL write_fields: awaddr=%h wdata=%h wstrb=%h prot=%b%b", axil.awaddr,
                      axil.wdata, axil.wstrb, axil.awprot, axil.arprot);
    end
    wait_rsp(base + 1, 20);
    total++;
    if (rsp_cyc - acc !== 3) begin
      bad++; $display("FAIL write_latency: got %0d required 3", rsp_cyc - acc);
    end
  endtask

  task automatic test_backpressure();
    int acc, aw_hi = 0, w_hi = 0, base = rsp_cnt;
    bit addr_bad = 1'b0;
    aw_delay = 2;
    send(1'b1, 20'h00340, 64'h55AA, 8'h0F, mk('0, 1'b0, 1'b0), acc);
    for (int i = 0; i < 12; i++) begin
      if (axil.awvalid === 1'b1) begin
        aw_hi++;
        if (axil.awaddr !== 20'h00340) addr_bad = 1'b1;
      end
      if (axil.wvalid === 1'b1) w_hi++;
      @(negedge clk);
    end
    aw_delay = 0;
    total += 3;
    if ({aw_hi, w_hi} !== {32'd3, 32'd1}) begin
      bad++; $display("FAIL bp_valid_cycles: aw=%0d w=%0d required 3/1", aw_hi, w_hi);
    end
    if (addr_bad) begin
      bad++; $display("FAIL bp_awaddr_stable: awaddr changed, required 00340");
    end
    if (rsp_cnt - base !== 1) begin
      bad++; $display("FAIL bp_one_rsp: got %0d responses required 1", rsp_cnt - base);
    end
  endtask

  task automatic test_rd_err();
    int acc, base = rsp_cnt;
    rd_val = 64'hCAFE; rd_resp = RESP_SLVERR;
    send(1'b0, 20'h00404, '0, '0, mk(64'hCAFE, 1'b1, 1'b0), acc);
    wait_rsp(base + 1, 20);
    rd_resp = RESP_OKAY;
  endtask

  task automatic test_back_to_back();
    int acc1, acc2, base = rsp_cnt;
    rd_val = 64'hA5;
    send(1'b0, 20'h00010, '0, '0, mk(64'hA5, 1'b0, 1'b0), acc1);
    send(1'b1, 20'h00018, 64'h77, 8'h01, mk('0, 1'b0, 1'b0), acc2);
    total++;
    if (acc2 - acc1 !== 4) begin
      bad++; $display("FAIL b2b_accept_gap: got %0d required 4", acc2 - acc1);
    end
    wait_rsp(base + 2, 20);
  endtask

`ifdef AXI4LITE_CSR_MST_TIMEOUT_EN
  task automatic test_timeout();
    int acc, base = rsp_cnt;
    ar_block = 1'b1;
    send(1'b0, 20'h002F0, '0, '0, mk('0, 1'b1, 1'b1), acc);
    wait_rsp(base + 1, 40);
    total += 2;
    if (rsp_cyc - acc !== TMO + 1) begin
      bad++; $display("FAIL tmo_latency: got %0d required %0d", rsp_cyc - acc, TMO + 1);
    end
    if (axil.arvalid !== 1'b0) begin
      bad++; $display("FAIL tmo_arvalid: got %b required 0", axil.arvalid);
    end
    ar_block = 1'b0;
    rd_val = 64'h77;
    send(1'b0, 20'h002F8, '0, '0, mk(64'h77, 1'b0, 1'b0), acc);
    wait_rsp(base + 2, 20);
  endtask
`endif

  task automatic test_reset_mid();
    int acc, base = rsp_cnt;
    b_hold = 1'b1;
    send(1'b1, 20'h00088, 64'h1, 8'h01, mk('0, 1'b0, 1'b0), acc);
    @(negedge clk);
    total++;
    if ({axil.awvalid, axil.wvalid, axil.bready} !== 3'b001) begin
      bad++; $display("FAIL rstmid_pre: aw/w/bready=%b required 001", {axil.awvalid, axil.wvalid, axil.bready});
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({axil.awvalid, axil.wvalid, axil.arvalid, axil.bready, axil.rready, req_ready} !== 6'b000001) begin
      bad++; $display("FAIL rstmid_async: valids/readies/req_ready=%b required 000001",
        {axil.awvalid, axil.wvalid, axil.arvalid, axil.bready, axil.rready, req_ready});
    end
    sb.delete();
    b_hold = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL rstmid_ready: got %b required 1", req_ready);
    end
    repeat (4) @(negedge clk);
    total++;
    if (rsp_cnt !== base) begin
      bad++; $display("FAIL rstmid_no_rsp: got %0d responses required %0d", rsp_cnt, base);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_rdata_hold();
    test_write();
    test_backpressure();
    test_rd_err();
    test_back_to_back();
`ifdef AXI4LITE_CSR_MST_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
